// File: rtl/conv_seq_ctrl.sv
// Sequencer for the full-size 1-D convolution datapath z[i] = sum_k x[k]*y[i-k].
// Drives X/Y read addresses, multiplier/accumulator strobes and Z writes.
module conv_seq_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] size_x,
  input  logic [ADDR_W-1:0] size_y,
  output logic [ADDR_W-1:0] addr_x,
  output logic [ADDR_W-1:0] addr_y,
  output logic              multi_reg_en,
  output logic              multi_reg_clr,
  output logic              acc_en,
  output logic              acc_clr,
  output logic [ADDR_W:0]   addr_z,
  output logic              we_z,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_READ  = 3'd2,
    S_MULT  = 3'd3,
    S_ACC   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] sx, sy, k;
  logic [ADDR_W:0]   i;
  logic [ADDR_W-1:0] ax_q, ay_q;
  logic [ADDR_W:0]   az_q;

  logic [ADDR_W:0]   sx_w, sy_w, k_w, kmax_w, last_i;
  logic [ADDR_W-1:0] kmin;
  logic              k_last, i_last;

  // Window bounds for output i; only meaningful while sizes are non-zero.
  always_comb begin
    sx_w   = {1'b0, sx};
    sy_w   = {1'b0, sy};
    k_w    = {1'b0, k};
    last_i = sx_w + sy_w - 2;
    kmax_w = (i < sx_w - 1) ? i : sx_w - 1;
    kmin   = '0;
    if (i + 1 > sy_w) kmin = i[ADDR_W-1:0] + 1 - sy;
    k_last = (k_w == kmax_w);
    i_last = (i == last_i);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (size_x == '0 || size_y == '0) ? S_DONE : S_SETUP;
      S_SETUP: state_nx = S_READ;
      S_READ:  state_nx = S_MULT;
      S_MULT:  state_nx = S_ACC;
      S_ACC:   state_nx = k_last ? S_WRITE : S_READ;
      S_WRITE: state_nx = i_last ? S_DONE : S_SETUP;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // ax_q/ay_q/az_q remember the last issued addresses so they hold outside READ/WRITE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sx   <= '0;
      sy   <= '0;
      i    <= '0;
      k    <= '0;
      ax_q <= '0;
      ay_q <= '0;
      az_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          sx <= size_x;
          sy <= size_y;
          i  <= '0;
        end
        S_SETUP: k <= kmin;
        S_READ: begin
          ax_q <= k;
          ay_q <= i[ADDR_W-1:0] - k;
        end
        S_ACC: if (!k_last) k <= k + 1'b1;
        S_WRITE: begin
          az_q <= i;
          if (!i_last) i <= i + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_x        = (state == S_READ)  ? k : ax_q;
    addr_y        = (state == S_READ)  ? (i[ADDR_W-1:0] - k) : ay_q;
    addr_z        = (state == S_WRITE) ? i : az_q;
    multi_reg_clr = (state == S_SETUP);
    acc_clr       = (state == S_SETUP);
    multi_reg_en  = (state == S_MULT);
    acc_en        = (state == S_ACC);
    we_z          = (state == S_WRITE);
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    fsm_state     = state;
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl with a small memory/multiplier/accumulator model
// so Z results can be checked alongside the address and strobe timing.
`timescale 1ns/1ps
module tb_conv_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start = 1'b0;
  logic [4:0] size_x = '0, size_y = '0;
  logic [4:0] addr_x, addr_y;
  logic [5:0] addr_z;
  logic       multi_reg_en, multi_reg_clr, acc_en, acc_clr, we_z, busy, done;
  logic [2:0] fsm_state;

  conv_seq_ctrl #(.ADDR_W(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .size_x(size_x), .size_y(size_y),
    .addr_x(addr_x), .addr_y(addr_y), .multi_reg_en(multi_reg_en),
    .multi_reg_clr(multi_reg_clr), .acc_en(acc_en), .acc_clr(acc_clr),
    .addr_z(addr_z), .we_z(we_z), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // ---------------- datapath model ----------------
  logic [7:0]  x_mem [32];
  logic [7:0]  y_mem [32];
  logic [15:0] z_mem [64];
  logic [7:0]  xd, yd;
  logic [15:0] mreg, acc;

  always @(posedge clk) begin
    xd <= x_mem[addr_x];
    yd <= y_mem[addr_y];
    if (multi_reg_clr)     mreg <= '0;
    else if (multi_reg_en) mreg <= 16'(xd * yd);
    if (acc_clr)           acc <= '0;
    else if (acc_en)       acc <= acc + mreg;
    if (we_z)              z_mem[addr_z] <= acc;
  end

  // ---------------- scoreboard state ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  int t0;
  int done_rel, first_busy, first_clr, first_mult, first_acc, first_we;
  int n_mult, n_acc, n_we;
  logic [9:0] obs_q [$];
  logic [9:0] exp_q [$];
  logic [5:0] wr_q  [$];

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [4:0] sx, input logic [4:0] sy);
    @(negedge clk);
    size_x = sx;
    size_y = sy;
    start  = 1'b1;
    t0     = cyc;
  endtask

  // Collects activity until done or max_rel; optionally pulses start with a new size_x.
  task automatic run(input int max_rel, input int pulse_rel, input logic [4:0] pulse_sx);
    int rel;
    done_rel = -1; first_busy = -1; first_clr = -1; first_mult = -1;
    first_acc = -1; first_we = -1; n_mult = 0; n_acc = 0; n_we = 0;
    obs_q.delete();
    wr_q.delete();
    forever begin
      @(negedge clk);
      rel = cyc - t0;
      if (rel == 1) start = 1'b0;
      if (rel == pulse_rel) begin
        start  = 1'b1;
        size_x = pulse_sx;
      end
      if (rel == pulse_rel + 1) start = 1'b0;
      if (busy && first_busy < 0) first_busy = rel;
      if (multi_reg_clr && first_clr < 0) first_clr = rel;
      if (multi_reg_en) begin
        if (first_mult < 0) first_mult = rel;
        n_mult++;
        obs_q.push_back({addr_x, addr_y});
      end
      if (acc_en) begin
        if (first_acc < 0) first_acc = rel;
        n_acc++;
      end
      if (we_z) begin
        if (first_we < 0) first_we = rel;
        n_we++;
        wr_q.push_back(addr_z);
      end
      if (done) begin
        done_rel = rel;
        break;
      end
      if (rel >= max_rel) break;
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic check_pairs(input string name);
    total_cnt++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL %s_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    else pass_cnt++;
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      total_cnt++;
      if (obs_q[n] !== exp_q[n])
        $display("FAIL %s[%0d]: got x=%0d y=%0d expected x=%0d y=%0d", name, n,
                 obs_q[n][9:5], obs_q[n][4:0], exp_q[n][9:5], exp_q[n][4:0]);
      else pass_cnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [24:0] outs;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    outs = {addr_x, addr_y, addr_z, multi_reg_en, multi_reg_clr, acc_en, acc_clr,
            we_z, busy, done, fsm_state};
    check_int("reset_outputs_in_reset", int'(outs), 0);
    rstn = 1'b1;
    @(negedge clk);
    outs = {addr_x, addr_y, addr_z, multi_reg_en, multi_reg_clr, acc_en, acc_clr,
            we_z, busy, done, fsm_state};
    check_int("reset_outputs_after", int'(outs), 0);
  endtask

  task automatic test_single();
    launch(5'd1, 5'd1);
    run(50, -10, 5'd0);
    check_int("single_setup_rel", first_clr, 1);
    check_int("single_mult_rel", first_mult, 3);
    check_int("single_acc_rel", first_acc, 4);
    check_int("single_we_rel", first_we, 5);
    check_int("single_we_count", n_we, 1);
    check_int("single_addr_z", (wr_q.size() > 0) ? int'(wr_q[0]) : -1, 0);
    check_int("single_done_rel", done_rel, 6);
    exp_q.delete();
    exp_q.push_back({5'd0, 5'd0});
    check_pairs("single_pairs");
  endtask

  task automatic expect_3x2();
    exp_q.delete();
    exp_q.push_back({5'd0, 5'd0});
    exp_q.push_back({5'd0, 5'd1});
    exp_q.push_back({5'd1, 5'd0});
    exp_q.push_back({5'd1, 5'd1});
    exp_q.push_back({5'd2, 5'd0});
    exp_q.push_back({5'd2, 5'd1});
    check_pairs("conv3x2_pairs");
    check_int("conv3x2_done_rel", done_rel, 27);
    check_int("conv3x2_we_count", n_we, 4);
    for (int n = 0; n < 4 && n < wr_q.size(); n++)
      check_int($sformatf("conv3x2_addr_z%0d", n), int'(wr_q[n]), n);
  endtask

  task automatic test_conv3x2();
    int z_exp [4] = '{1, 3, 5, 3};
    for (int n = 0; n < 64; n++) z_mem[n] = '0;
    x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
    y_mem[0] = 8'd1; y_mem[1] = 8'd1;
    launch(5'd3, 5'd2);
    run(100, -10, 5'd0);
    expect_3x2();
    @(negedge clk);
    for (int n = 0; n < 4; n++)
      check_int($sformatf("conv3x2_z%0d", n), int'(z_mem[n]), z_exp[n]);
  endtask

  task automatic test_zero_size();
    launch(5'd0, 5'd5);
    run(20, -10, 5'd0);
    check_int("zero_done_rel", done_rel, 1);
    check_int("zero_strobes", n_we + n_mult + n_acc, 0);
    @(negedge clk);
    check_int("zero_idle_after", int'(busy), 0);
  endtask

  task automatic test_start_while_busy();
    launch(5'd3, 5'd2);
    run(100, 10, 5'd7);
    expect_3x2();
    @(negedge clk);
    check_int("busy_restart_idle", int'(busy), 0);
  endtask

  task automatic test_reset_mid_run();
    int rel;
    int saw_done = 0;
    logic [24:0] outs;
    launch(5'd3, 5'd2);
    for (rel = 1; rel < 50; rel++) begin
      @(negedge clk);
      if (rel == 1) start = 1'b0;
      if (multi_reg_en) break;
    end
    check_int("midrst_reached_mult", int'(multi_reg_en), 1);
    rstn = 1'b0;
    #1;
    outs = {addr_x, addr_y, addr_z, multi_reg_en, multi_reg_clr, acc_en, acc_clr,
            we_z, busy, done, fsm_state};
    check_int("midrst_outputs", int'(outs), 0);
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check_int("midrst_no_done", saw_done, 0);
    launch(5'd1, 5'd1);
    run(50, -10, 5'd0);
    check_int("midrst_rerun_done_rel", done_rel, 6);
    check_int("midrst_rerun_we_rel", first_we, 5);
  endtask

  task automatic test_back_to_back();
    int rel;
    int d0 = -1, d1 = -1;
    launch(5'd1, 5'd1);
    for (rel = 1; rel <= 30; rel++) begin
      @(negedge clk);
      if (done) begin
        if (d0 < 0) d0 = rel;
        else begin
          d1 = rel;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check_int("b2b_done0_rel", d0, 6);
    check_int("b2b_done1_rel", d1, 13);
    repeat (2) @(negedge clk);
    check_int("b2b_idle_after", int'(busy), 0);
  endtask

  task automatic test_max_size();
    launch(5'd31, 5'd31);
    run(4000, -10, 5'd0);
    check_int("max_done_rel", done_rel, 3006);
    check_int("max_we_count", n_we, 61);
    check_int("max_last_addr_z", (wr_q.size() > 0) ? int'(wr_q[wr_q.size()-1]) : -1, 60);
    check_int("max_busy_span", done_rel - first_busy, 3005);
    check_int("max_mult_count", n_mult, 961);
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    for (int n = 0; n < 32; n++) begin
      x_mem[n] = '0;
      y_mem[n] = '0;
    end
    test_reset();
    test_single();
    test_conv3x2();
    test_zero_size();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_max_size();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
